nms_frame_ctrl: RTL and testbench

NMS_FRAME_CTRL -- requirements
Module: nms_frame_ctrl

---
 rtl/nms_frame_ctrl.sv | 144 ++++++++++++++
 tb/tb_nms_frame_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/nms_frame_ctrl.sv
// nms_frame_ctrl: frame sequencer for the non-maximum-suppression datapath.
// Forwards one frame of pixels into the NMS stage, follows the delayed result
// stream with its own coordinate counters and emits border-filtered keypoints.
// Optional build macro NMS_KP_CAP_EN: caps keypoints per frame at MAX_KP.
module nms_frame_ctrl #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int BORDER = 3,
  parameter int MAX_KP = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_valid,
  input  logic [7:0]  i_score,
  input  logic        i_flag,
  output logic [7:0]  o_nms_score,
  output logic        o_nms_flag,
  input  logic [7:0]  i_nms_score,
  input  logic        i_nms_flag,
  output logic        o_kp_valid,
  output logic [11:0] o_kp_x,
  output logic [11:0] o_kp_y,
  output logic [7:0]  o_kp_score,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [15:0] o_kp_count,
  output logic        o_err
);

`ifdef NMS_KP_CAP_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  localparam logic [12:0] LAT    = 13'(WIDTH + 5);
  localparam logic [11:0] XMAX   = 12'(WIDTH - 1);
  localparam logic [11:0] YMAX   = 12'(HEIGHT - 1);
  localparam logic [11:0] HROWS  = 12'(HEIGHT);
  localparam logic [11:0] B_LO   = 12'(BORDER);
  localparam logic [11:0] X_HI   = 12'(WIDTH - BORDER);
  localparam logic [11:0] Y_HI   = 12'(HEIGHT - BORDER);
  localparam logic [15:0] KP_CAP = 16'(MAX_KP);

  typedef enum logic [2:0] {IDLE, WAIT, RUN, FLUSH, DONE} state_t;

  state_t      state, state_n;
  logic [11:0] in_x, in_y, out_x, out_y;
  logic [12:0] lead, flush_cnt;
  logic        accept, fwd, abort, last_pix, live, kp_hit, cap_ok;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  // Next state, pixel forwarding and status outputs
  always_comb begin
    state_n      = state;
    accept       = 1'b0;
    fwd          = 1'b0;
    abort        = 1'b0;
    o_nms_score  = '0;
    o_nms_flag   = 1'b0;
    o_busy       = (state != IDLE);
    o_frame_done = 1'b0;
    last_pix     = (in_x == XMAX) && (in_y == YMAX);
    case (state)
      IDLE:  if (i_start) begin
               accept  = 1'b1;
               state_n = WAIT;
             end
      WAIT:  if (i_valid) begin
               fwd     = 1'b1;
               state_n = RUN;
             end
      RUN:   if (i_valid) begin
               fwd = 1'b1;
               if (last_pix) state_n = FLUSH;
             end else begin
               abort   = 1'b1;
               state_n = FLUSH;
             end
      FLUSH: if (flush_cnt == LAT - 13'd1) state_n = DONE;
      DONE:  begin
               o_frame_done = 1'b1;
               state_n      = IDLE;
             end
      default: state_n = IDLE;
    endcase
    if (fwd) begin
      o_nms_score = i_score;
      o_nms_flag  = i_flag;
    end
  end

  // Result-stream qualification: the output counters only run once the
  // datapath latency has elapsed since pixel 0, and stop after the last row.
  always_comb begin
    cap_ok = !CAP_EN || (o_kp_count < KP_CAP);
    live   = ((state == RUN) || (state == FLUSH)) && (lead == LAT) && (out_y != HROWS);
    kp_hit = live && i_nms_flag && !o_err && cap_ok &&
             (out_x >= B_LO) && (out_x < X_HI) &&
             (out_y >= B_LO) && (out_y < Y_HI);
  end

  // Coordinate counters, latency tracker, keypoint register and status flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      in_x <= '0; in_y <= '0; out_x <= '0; out_y <= '0;
      lead <= '0; flush_cnt <= '0;
      o_kp_valid <= 1'b0; o_kp_x <= '0; o_kp_y <= '0; o_kp_score <= '0;
      o_kp_count <= '0; o_err <= 1'b0;
    end else begin
      o_kp_valid <= kp_hit;
      if (kp_hit) begin
        o_kp_x     <= out_x;
        o_kp_y     <= out_y;
        o_kp_score <= i_nms_score;
        if (o_kp_count != 16'hFFFF) o_kp_count <= o_kp_count + 16'd1;
      end
      flush_cnt <= (state == FLUSH) ? flush_cnt + 13'd1 : '0;
      if (abort) o_err <= 1'b1;
      if (accept) begin
        in_x <= '0; in_y <= '0; out_x <= '0; out_y <= '0;
        lead <= '0; o_kp_count <= '0; o_err <= 1'b0;
      end else begin
        if (fwd && state == WAIT) lead <= 13'd1;
        else if (((state == RUN) || (state == FLUSH)) && lead != LAT) lead <= lead + 13'd1;
        if (fwd) begin
          if (in_x == XMAX) begin in_x <= '0; in_y <= in_y + 12'd1; end
          else in_x <= in_x + 12'd1;
        end
        if (live) begin
          if (out_x == XMAX) begin out_x <= '0; out_y <= out_y + 12'd1; end
          else out_x <= out_x + 12'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nms_frame_ctrl.sv
// Bench for nms_frame_ctrl: plans a timeline of frames (directed + random),
// predicts every output per cycle from frame timing rules, compares each cycle.
module tb_nms_frame_ctrl;
  localparam int W = 8, H = 6, B = 1, MK = 2;
  localparam int LAT = W + 5, NPIX = W * H, NC = 4000, MAXF = 64, NOR = 1 << 30;
`ifdef NMS_KP_CAP_EN
  localparam bit CAP = 1'b1;
  localparam int KP3 = 2;
`else
  localparam bit CAP = 1'b0;
  localparam int KP3 = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, valid = 1'b0, flag = 1'b0, nfl = 1'b0;
  logic [7:0] score = '0, nscore = '0;
  logic [7:0] o_nsc, ks;
  logic o_nfl, kv, busy, done, err;
  logic [11:0] kx, ky;
  logic [15:0] cnt;

  nms_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .BORDER(B), .MAX_KP(MK)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
    .i_score(score), .i_flag(flag), .o_nms_score(o_nsc), .o_nms_flag(o_nfl),
    .i_nms_score(nscore), .i_nms_flag(nfl), .o_kp_valid(kv), .o_kp_x(kx),
    .o_kp_y(ky), .o_kp_score(ks), .o_busy(busy), .o_frame_done(done),
    .o_kp_count(cnt), .o_err(err));

  bit s_rst[NC], s_start[NC], s_valid[NC], s_flag[NC], s_nfl[NC];
  int s_sc[NC], s_nsc[NC];
  int fS[MAXF], fP0[MAXF], fE[MAXF], fR[MAXF], fStop[MAXF];
  bit fAb[MAXF], fEcho[MAXF];
  int nf = 0;
  int e_busy[NC], e_done[NC], e_err[NC], e_nsc[NC], e_nfl[NC];
  int e_kv[NC], e_kx[NC], e_ky[NC], e_ks[NC], e_cnt[NC];
  int lit_c[$], lit_k[$], lit_v[$];
  int total = 0, bad = 0;

  // Frame f: start seen in cycle fS, pixel 0 in fP0, last forwarded/abort in fE,
  // flush fE+1..fE+LAT, done in fE+LAT+1; reset driven in fR truncates it.
  task automatic plan_frame(input int s, input int gap, input int ab, input int rpx,
                            input bit echo, output int p0);
    int f, n;
    f = nf; nf++;
    fS[f] = s; s_start[s] = 1'b1; p0 = s + 1 + gap;
    for (int c = s + 1; c < p0; c++) s_valid[c] = 1'b0;
    n = (ab < 0) ? NPIX : ab;
    for (int k = 0; k < n; k++) s_valid[p0 + k] = 1'b1;
    if (ab < 0) fE[f] = p0 + NPIX - 1;
    else begin s_valid[p0 + ab] = 1'b0; fE[f] = p0 + ab; end
    fAb[f] = (ab >= 0); fP0[f] = p0; fEcho[f] = echo;
    if (rpx >= 0) begin fR[f] = p0 + rpx; s_rst[fR[f]] = 1'b1; fStop[f] = fR[f]; end
    else begin fR[f] = NOR; fStop[f] = fE[f] + LAT + 1; end
    for (int c = s + 1; c <= fStop[f]; c++) if ($urandom % 16 == 0) s_start[c] = 1'b1;
  endtask

  task automatic add_lit(input int c, input int k, input int v);
    lit_c.push_back(c); lit_k.push_back(k); lit_v.push_back(v);
  endtask

  function automatic int frame_at(input int c);
    for (int f = 0; f < nf; f++) if (fS[f] <= c && c <= fStop[f]) return f;
    return -1;
  endfunction

  task automatic build_model(input int last);
    int merr, mcnt, mkx, mky, mks, mkv, g, pc, j;
    merr = 0; mcnt = 0; mkx = 0; mky = 0; mks = 0; mkv = 0;
    for (int c = 0; c <= last; c++) begin
      if (c == 0 || s_rst[c-1]) begin
        merr = 0; mcnt = 0; mkx = 0; mky = 0; mks = 0; mkv = 0;
      end else begin
        pc = c - 1; g = frame_at(pc); mkv = 0;
        if (g >= 0) begin
          if (pc == fS[g]) begin mcnt = 0; merr = 0; end
          else begin
            j = pc - fP0[g] - LAT;
            if (j >= 0 && j < NPIX && merr == 0 && s_nfl[pc] &&
                (j % W) >= B && (j % W) < W - B && (j / W) >= B && (j / W) < H - B &&
                (!CAP || mcnt < MK)) begin
              mkv = 1; mkx = j % W; mky = j / W; mks = s_nsc[pc];
              if (mcnt < 65535) mcnt++;
            end
            if (fAb[g] && pc == fE[g]) merr = 1;
          end
        end
      end
      e_err[c] = merr; e_cnt[c] = mcnt; e_kv[c] = mkv;
      e_kx[c] = mkx; e_ky[c] = mky; e_ks[c] = mks;
      g = frame_at(c);
      e_busy[c] = (g >= 0 && c > fS[g]) ? 1 : 0;
      e_done[c] = (g >= 0 && fR[g] == NOR && c == fStop[g]) ? 1 : 0;
      if (g >= 0 && c >= fP0[g] && c <= fE[g] && s_valid[c]) begin
        e_nsc[c] = s_sc[c]; e_nfl[c] = int'(s_flag[c]);
      end else begin
        e_nsc[c] = 0; e_nfl[c] = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input int c, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, c, got, exp);
    end
  endtask

  function automatic int act(input int k);
    case (k)
      0: return int'(kv);
      1: return int'(kx);
      2: return int'(ky);
      3: return int'(ks);
      4: return int'(cnt);
      5: return int'(done);
      6: return int'(err);
      default: return int'(busy);
    endcase
  endfunction

  initial begin
    int cur, p0, last, src, f, ab, rpx;
    for (int c = 0; c < NC; c++) begin
      s_valid[c] = ($urandom % 2) == 1; s_flag[c] = ($urandom % 2) == 1;
      s_nfl[c] = ($urandom % 3) == 0;
      s_sc[c] = int'($urandom % 256); s_nsc[c] = int'($urandom % 256);
    end
    s_rst[0] = 1'b1; s_rst[1] = 1'b1; s_rst[2] = 1'b1;
    cur = 5;
    // Single interior peak at (4,3), score 50; stray start mid-frame
    plan_frame(cur, 2, -1, -1, 1'b1, p0);
    for (int k = 0; k < NPIX; k++) s_flag[p0 + k] = 1'b0;
    s_flag[p0 + 28] = 1'b1; s_sc[p0 + 28] = 50; s_start[p0 + 10] = 1'b1;
    add_lit(p0 + 28 + 13, 0, 0);
    add_lit(p0 + 28 + 14, 0, 1); add_lit(p0 + 28 + 14, 1, 4);
    add_lit(p0 + 28 + 14, 2, 3); add_lit(p0 + 28 + 14, 3, 50);
    add_lit(p0 + 28 + 14, 4, 1); add_lit(p0 + 47 + 14, 5, 1);
    add_lit(0, 7, 0); add_lit(0, 4, 0); add_lit(0, 0, 0);
    cur = fStop[nf-1] + 2;
    // Border peaks only
    plan_frame(cur, 0, -1, -1, 1'b1, p0);
    for (int k = 0; k < NPIX; k++) s_flag[p0 + k] = 1'b0;
    s_flag[p0 + 16] = 1'b1; s_flag[p0 + 47] = 1'b1;
    add_lit(p0 + 47 + 13, 5, 0); add_lit(p0 + 47 + 14, 5, 1); add_lit(p0 + 47 + 14, 4, 0);
    cur = fStop[nf-1] + 1;
    // Abort at pixel 20
    plan_frame(cur, 1, 20, -1, 1'b0, p0);
    add_lit(p0 + 20, 6, 0); add_lit(p0 + 21, 6, 1);
    add_lit(p0 + 33, 5, 0); add_lit(p0 + 34, 5, 1); add_lit(p0 + 34, 4, 0);
    cur = fStop[nf-1] + 3;
    // Reset during RUN at pixel 10; accepted start clears the sticky error
    add_lit(cur, 6, 1); add_lit(cur + 1, 6, 0);
    plan_frame(cur, 3, -1, 10, 1'b0, p0);
    add_lit(p0 + 10, 7, 1); add_lit(p0 + 11, 7, 0); add_lit(p0 + 11, 4, 0);
    cur = fStop[nf-1] + 2;
    // Three isolated interior peaks
    plan_frame(cur, 0, -1, -1, 1'b1, p0);
    for (int k = 0; k < NPIX; k++) s_flag[p0 + k] = 1'b0;
    s_flag[p0 + 18] = 1'b1; s_flag[p0 + 21] = 1'b1; s_flag[p0 + 35] = 1'b1;
    add_lit(p0 + 47 + 14, 4, KP3);
    cur = fStop[nf-1] + 1;
    // Random frames
    while (nf < 24 && cur < NC - 200) begin
      ab  = ($urandom % 5 == 0) ? int'($urandom % NPIX) : -1;
      rpx = -1;
      if ($urandom % 8 == 0) rpx = int'($urandom % ((ab < 0) ? NPIX : ab + 1));
      plan_frame(cur, int'($urandom % 4), ab, rpx, ($urandom % 2) == 1, p0);
      cur = fStop[nf-1] + 1 + int'($urandom % 3);
    end
    last = cur + 5;
    // Echo frames: result stream is the forwarded stream delayed by the latency
    for (f = 0; f < nf; f++) if (fEcho[f])
      for (int c = fS[f] + 1; c <= fStop[f]; c++) begin
        src = c - LAT;
        if (src >= fP0[f] && src <= fE[f] && s_valid[src]) begin
          s_nsc[c] = s_sc[src]; s_nfl[c] = s_flag[src];
        end else begin
          s_nsc[c] = 0; s_nfl[c] = 1'b0;
        end
      end
    build_model(last);

    for (int c = 0; c <= last; c++) begin
      @(posedge clk);
      #1;
      rst = s_rst[c]; start = s_start[c]; valid = s_valid[c]; flag = s_flag[c];
      score = 8'(s_sc[c]); nscore = 8'(s_nsc[c]); nfl = s_nfl[c];
      @(negedge clk);
      chk("busy", c, int'(busy), e_busy[c]);
      chk("frame_done", c, int'(done), e_done[c]);
      chk("err", c, int'(err), e_err[c]);
      chk("nms_score", c, int'(o_nsc), e_nsc[c]);
      chk("nms_flag", c, int'(o_nfl), e_nfl[c]);
      chk("kp_valid", c, int'(kv), e_kv[c]);
      chk("kp_x", c, int'(kx), e_kx[c]);
      chk("kp_y", c, int'(ky), e_ky[c]);
      chk("kp_score", c, int'(ks), e_ks[c]);
      chk("kp_count", c, int'(cnt), e_cnt[c]);
      for (int i = 0; i < lit_c.size(); i++)
        if (lit_c[i] == c) chk("literal", c, act(lit_k[i]), lit_v[i]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
